// File: rtl/dmem_lsu.sv
// Handshaked RV32I load/store unit in front of an on-chip word RAM.
// Programmable wait states; faults for misaligned, out-of-range and illegal-funct3 requests.
module dmem_lsu #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [1:0]  rsp_cause
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic          cur_we;
  logic [2:0]    cur_f3;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic          commit_c;
  logic          illegal_c;
  logic          misal_c;
  logic          range_c;
  logic [1:0]    cause_c;
  logic          fault_c;
  logic [AW-1:0] idx_c;
  logic [31:0]   word_c;
  logic [7:0]    byte_c;
  logic [15:0]   half_c;
  logic [31:0]   load_c;
  logic [31:0]   rdata_c;
  logic [3:0]    be_c;
  logic [31:0]   wdat_c;
  logic          mem_wr_c;

  // With zero wait states the commit happens on the accept edge, before fields are latched.
  always_comb begin
    cur_we    = lat_we;
    cur_f3    = lat_f3;
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    if (state == IDLE) begin
      cur_we    = req_we;
      cur_f3    = req_funct3;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end
    commit_c = ((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
               ((state == WAIT) && (cnt == 4'(WAIT_CYCLES)));
  end

  // Fault decode, priority illegal > misaligned > range.
  always_comb begin
    if (cur_we) illegal_c = (cur_f3 > 3'd2);
    else        illegal_c = (cur_f3 == 3'd3) || (cur_f3[2:1] == 2'b11);
    misal_c = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
              ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
    range_c = ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    if (illegal_c)    cause_c = 2'b11;
    else if (misal_c) cause_c = 2'b01;
    else if (range_c) cause_c = 2'b10;
    else              cause_c = 2'b00;
    fault_c = (cause_c != 2'b00);
  end

  // Little-endian lane extraction and extension for loads.
  always_comb begin
    idx_c  = cur_addr[AW+1:2];
    word_c = mem[idx_c];
    case (cur_addr[1:0])
      2'd0:    byte_c = word_c[7:0];
      2'd1:    byte_c = word_c[15:8];
      2'd2:    byte_c = word_c[23:16];
      default: byte_c = word_c[31:24];
    endcase
    half_c = cur_addr[1] ? word_c[31:16] : word_c[15:0];
    case (cur_f3)
      3'd0:    load_c = {{24{byte_c[7]}}, byte_c};
      3'd4:    load_c = {24'd0, byte_c};
      3'd1:    load_c = {{16{half_c[15]}}, half_c};
      3'd5:    load_c = {16'd0, half_c};
      default: load_c = word_c;
    endcase
    rdata_c = (fault_c || cur_we) ? 32'd0 : load_c;
  end

  // Byte enables and replicated store data.
  always_comb begin
    case (cur_f3)
      3'd0: begin
        be_c   = 4'b0001 << cur_addr[1:0];
        wdat_c = {4{cur_wdata[7:0]}};
      end
      3'd1: begin
        be_c   = cur_addr[1] ? 4'b1100 : 4'b0011;
        wdat_c = {2{cur_wdata[15:0]}};
      end
      default: begin
        be_c   = 4'b1111;
        wdat_c = cur_wdata;
      end
    endcase
    mem_wr_c = commit_c && cur_we && !fault_c && !rst;
  end

  always_ff @(posedge clk) begin
    if (mem_wr_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem[idx_c][8*b +: 8] <= wdat_c[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_fault <= 1'b0;
      rsp_cause <= 2'b00;
      lat_we    <= 1'b0;
      lat_f3    <= 3'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_f3    <= req_funct3;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= 4'd1;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'(WAIT_CYCLES)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            cnt       <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
      if (commit_c) begin
        rsp_rdata <= rdata_c;
        rsp_fault <= fault_c;
        rsp_cause <= cause_c;
      end
    end
  end

endmodule
